// File: rtl/status_bit_arbiter.sv
// 64 x 1-bit cache status array (4 banks x 16) with a shared access port for two requesters
// and a 4-cycle invalidate-all flush. Define ARB_FIXED_PRIO_EN for fixed priority (requester 0).
module status_bit_arbiter #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [IDX_W-1:0] idx0_i,
    input  logic [IDX_W-1:0] idx1_i,
    input  logic             wr0_i,
    input  logic             wr1_i,
    input  logic             wdata0_i,
    input  logic             wdata1_i,
    input  logic             flush_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             rdata0_o,
    output logic             rdata1_o,
    output logic             rvalid0_o,
    output logic             rvalid1_o,
    output logic             busy_o
);

    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = ENTRIES / NUM_BANKS;
    localparam int BIT_W     = IDX_W - 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    bank_cnt_q, bank_cnt_d;
    logic          arb_en;
    logic          clr_en;

    logic [BANK_W-1:0] mem_q [NUM_BANKS];

    logic             tie_win1;
    logic             acc_en;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_wr;
    logic             acc_wdata;
    logic [BANK_W-1:0] bank_word;
    logic             rd_bit;

    logic rdata0_q, rdata1_q;
    logic rvalid0_q, rvalid1_q;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bank_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            bank_cnt_q <= bank_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d    = state_q;
        bank_cnt_d = bank_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d    = ST_FLUSH;
                    bank_cnt_d = 2'd0;
                end
            end
            ST_FLUSH: begin
                bank_cnt_d = bank_cnt_q + 2'd1;
                if (bank_cnt_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A flush request in IDLE suppresses arbitration that cycle; flush_i is ignored once flushing.
    always_comb begin
        busy_o = 1'b0;
        arb_en = 1'b0;
        clr_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                arb_en = ~flush_i;
            end
            ST_FLUSH: begin
                busy_o = 1'b1;
                clr_en = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- Arbitration ----------------
`ifdef ARB_FIXED_PRIO_EN
    assign tie_win1 = 1'b0;
`else
    logic rr_ptr_q;  // 0 = requester 0 wins the next tie

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (gnt0_o) begin
            rr_ptr_q <= 1'b1;
        end else if (gnt1_o) begin
            rr_ptr_q <= 1'b0;
        end
    end

    assign tie_win1 = rr_ptr_q;
`endif

    assign gnt0_o = arb_en & req0_i & (~req1_i | ~tie_win1);
    assign gnt1_o = arb_en & req1_i & (~req0_i |  tie_win1);

    // ---------------- Shared access port ----------------
    always_comb begin
        acc_en    = gnt0_o | gnt1_o;
        acc_idx   = gnt1_o ? idx1_i   : idx0_i;
        acc_wr    = gnt1_o ? wr1_i    : wr0_i;
        acc_wdata = gnt1_o ? wdata1_i : wdata0_i;
    end

    // Two-level select: bank word first, then the bit within it.
    assign bank_word = mem_q[acc_idx[IDX_W-1:BIT_W]];
    assign rd_bit    = bank_word[acc_idx[BIT_W-1:0]];

    // ---------------- Status array ----------------
    // NOTE: this array is flop-based and must be cleared by reset, so it carries an async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem_q[b] <= '0;
            end
        end else if (clr_en) begin
            mem_q[bank_cnt_q] <= '0;
        end else if (acc_en && acc_wr) begin
            mem_q[acc_idx[IDX_W-1:BIT_W]][acc_idx[BIT_W-1:0]] <= acc_wdata;
        end
    end

    // ---------------- Read return ----------------
    // rd_bit is the pre-edge value, giving read-before-write on a granted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q  <= 1'b0;
            rdata1_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0_o;
            rvalid1_q <= gnt1_o;
            if (gnt0_o) begin
                rdata0_q <= rd_bit;
            end
            if (gnt1_o) begin
                rdata1_q <= rd_bit;
            end
        end
    end

    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;

endmodule

// File: tb/tb_status_bit_arbiter.sv
// Scoreboard bench for status_bit_arbiter: stimulus pushes expected read data per requester,
// a negedge monitor pops and compares whenever rvalid is seen.
module tb_status_bit_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [5:0] idx0, idx1;
    logic       wr0, wr1, wdata0, wdata1;
    logic       flush;
    logic       gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, busy;

    int n_cmp  = 0;
    int n_fail = 0;
    bit q0[$];
    bit q1[$];

    always #5 clk = ~clk;

    status_bit_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0_i    (req0),
        .req1_i    (req1),
        .idx0_i    (idx0),
        .idx1_i    (idx1),
        .wr0_i     (wr0),
        .wr1_i     (wr1),
        .wdata0_i  (wdata0),
        .wdata1_i  (wdata1),
        .flush_i   (flush),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1),
        .rdata0_o  (rdata0),
        .rdata1_o  (rdata1),
        .rvalid0_o (rvalid0),
        .rvalid1_o (rvalid1),
        .busy_o    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest expected value for that requester.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid0) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rvalid0 with empty scoreboard: got rdata0=%0b expected none", rdata0);
                end else begin
                    check("rdata0", rdata0, q0.pop_front());
                end
            end
            if (rvalid1) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rvalid1 with empty scoreboard: got rdata1=%0b expected none", rdata1);
                end else begin
                    check("rdata1", rdata1, q1.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the grant edge.
    task automatic access(input bit r, input logic [5:0] idx, input bit wr, input bit wdata,
                          input bit exp_old);
        bit granted = 1'b0;
        if (r == 1'b0) begin
            req0 = 1'b1; idx0 = idx; wr0 = wr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; idx1 = idx; wr1 = wr; wdata1 = wdata;
        end
        for (int c = 0; c < 20 && !granted; c++) begin
            #2;
            if ((r == 1'b0 && gnt0 === 1'b1) || (r == 1'b1 && gnt1 === 1'b1)) begin
                granted = 1'b1;
                if (r == 1'b0) q0.push_back(exp_old);
                else           q1.push_back(exp_old);
            end
            @(posedge clk); #1;
        end
        if (!granted) begin
            n_cmp++; n_fail++;
            $display("FAIL access timeout: requester %0d idx %0d got no grant, expected one", r, idx);
        end
        req0 = 1'b0; wr0 = 1'b0;
        req1 = 1'b0; wr1 = 1'b0;
    endtask

    // Assert reset mid-run between clock edges; all outputs must go to 0 immediately.
    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("outputs in reset", {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy}, 7'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("outputs after reset", {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy}, 7'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; idx0 = 0; idx1 = 0;
        wr0 = 0; wr1 = 0; wdata0 = 0; wdata1 = 0; flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // 1: make rdata0 non-zero, reset mid-run, then every entry reads 0
        access(0, 6'd2, 1, 1, 0);
        access(0, 6'd2, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 64; i++) begin
            access(0, 6'(i), 0, 0, 0);
        end

        // 2: write/read idx 37, rdata hold, neighbouring decode
        access(0, 6'd37, 1, 1, 0);
        access(0, 6'd37, 0, 0, 1);
        @(posedge clk); #3;
        check("rdata0 hold with rvalid0=0", {rvalid0, rdata0}, 2'b01);
        @(posedge clk); #1;
        access(0, 6'd36, 0, 0, 0);
        access(0, 6'd53, 0, 0, 0);

        // 3: both requesters held for 6 cycles from a fresh pointer
        do_reset();
        req0 = 1; idx0 = 6'd0; wr0 = 0;
        req1 = 1; idx1 = 6'd1; wr1 = 0;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_g;
`ifdef ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #2;
            check("tie grant {gnt1,gnt0}", {gnt1, gnt0}, exp_g);
            if (exp_g[0]) q0.push_back(1'b0);
            else          q1.push_back(1'b0);
            @(posedge clk); #1;
        end
        req0 = 0; req1 = 0;
        @(posedge clk); #1;

        // 4: set bits, flush with req1 pending
        access(0, 6'd5,  1, 1, 0);
        access(0, 6'd21, 1, 1, 0);
        access(0, 6'd42, 1, 1, 0);
        access(0, 6'd63, 1, 1, 0);
        flush = 1; req1 = 1; idx1 = 6'd5; wr1 = 0;
        #2;
        check("flush cycle {busy,gnt1,gnt0}", {busy, gnt1, gnt0}, 3'b000);
        @(posedge clk); #1;
        flush = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("flushing {busy,gnt1,gnt0}", {busy, gnt1, gnt0}, 3'b100);
            @(posedge clk); #1;
        end
        #2;
        check("after flush {busy,gnt1,gnt0}", {busy, gnt1, gnt0}, 3'b010);
        q1.push_back(1'b0);
        @(posedge clk); #1;
        req1 = 0;
        access(0, 6'd21, 0, 0, 0);
        access(0, 6'd42, 0, 0, 0);
        access(0, 6'd63, 0, 0, 0);

        // 5a: second flush pulse in flush cycle 2 is ignored
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        #2; check("flush c1 busy", busy, 1'b1);
        @(posedge clk); #1;
        flush = 1;
        #2; check("flush c2 busy", busy, 1'b1);
        @(posedge clk); #1;
        flush = 0;
        #2; check("flush c3 busy", busy, 1'b1);
        @(posedge clk); #1;
        #2; check("flush c4 busy", busy, 1'b1);
        @(posedge clk); #1;
        #2; check("flush c5 busy", busy, 1'b0);
        @(posedge clk); #1;

        // 5b: reset in flush cycle 2
        access(0, 6'd7,  1, 1, 0);
        access(1, 6'd60, 1, 1, 0);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        check("busy on reset mid-flush", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        access(0, 6'd7,  0, 0, 0);
        access(1, 6'd60, 0, 0, 0);

        // 6: read-before-write, back-to-back on one entry
        access(1, 6'd10, 1, 1, 0);
        access(1, 6'd10, 1, 1, 1);
        access(1, 6'd10, 1, 0, 1);
        access(1, 6'd10, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard q0 drained", q0.size(), 0);
        check("scoreboard q1 drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
